// File: rtl/window_slide_ctrl.sv
// window_slide_ctrl
// Owns one window_slide instance: streams a binary image from a single-port
// buffer into it, then requests windows one at a time (gated by win_ready),
// tags each returned window with row/column/index and reports done, or a
// sticky error when window_slide fails to answer within TIMEOUT cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start
// S_LOAD   | reading the image buffer, streaming pixels to window_slide
// S_SLIDE  | next window may be requested once win_ready is high
// S_WAIT   | one window outstanding, waiting for ws_valid or timeout
// S_FINISH | all windows delivered, pulse done for one cycle

module window_slide_ctrl #(
    parameter  int IMAGE_ROW_LEN = 10,
    parameter  int IMAGE_COL_LEN = 20,
    parameter  int KERNEL_SIZE   = 3,
    parameter  int STRIDE        = 1,
    parameter  int TIMEOUT       = 64,
    localparam int IMAGE_SIZE    = IMAGE_ROW_LEN * IMAGE_COL_LEN,
    localparam int OUT_ROWS      = (IMAGE_ROW_LEN - KERNEL_SIZE) / STRIDE + 1,
    localparam int OUT_COLS      = (IMAGE_COL_LEN - KERNEL_SIZE) / STRIDE + 1,
    localparam int NUM_WIN       = OUT_ROWS * OUT_COLS,
    localparam int AW            = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1,
    localparam int IW            = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1,
    localparam int RW            = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1,
    localparam int CW            = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1,
    localparam int TW            = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          img_rd_en,
    output logic [AW-1:0] img_addr,
    input  logic          img_rd_data,
    output logic          ws_new_image,
    output logic          ws_x_in,
    output logic          ws_slide,
    input  logic          ws_valid,
    input  logic          win_ready,
    output logic          win_valid,
    output logic [IW-1:0] win_index,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SLIDE,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t        state;

    // Read pipeline: pix_* line up with img_rd_data, x_last with ws_x_in.
    logic          pix_vld;
    logic          pix_first;
    logic          pix_last;
    logic          x_last;

    logic [IW-1:0] idx;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [TW-1:0] to_cnt;

    // Sequencer FSM, read pipeline, window counters and timeout down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            img_rd_en    <= 1'b0;
            img_addr     <= '0;
            ws_new_image <= 1'b0;
            ws_x_in      <= 1'b0;
            ws_slide     <= 1'b0;
            win_valid    <= 1'b0;
            win_index    <= '0;
            win_row      <= '0;
            win_col      <= '0;
            pix_vld      <= 1'b0;
            pix_first    <= 1'b0;
            pix_last     <= 1'b0;
            x_last       <= 1'b0;
            idx          <= '0;
            row          <= '0;
            col          <= '0;
            to_cnt       <= '0;
        end else begin
            done         <= 1'b0;
            ws_slide     <= 1'b0;
            win_valid    <= 1'b0;
            ws_new_image <= 1'b0;
            ws_x_in      <= 1'b0;
            pix_vld      <= 1'b0;
            pix_first    <= 1'b0;
            pix_last     <= 1'b0;
            x_last       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        img_rd_en <= 1'b1;
                        img_addr  <= '0;
                        idx       <= '0;
                        row       <= '0;
                        col       <= '0;
                        to_cnt    <= '0;
                        win_index <= '0;
                        win_row   <= '0;
                        win_col   <= '0;
                    end
                end

                S_LOAD: begin
                    pix_vld      <= img_rd_en;
                    pix_first    <= img_rd_en && (img_addr == '0);
                    pix_last     <= img_rd_en && (img_addr == AW'(IMAGE_SIZE - 1));
                    ws_x_in      <= pix_vld & img_rd_data;
                    ws_new_image <= pix_vld & pix_first;
                    x_last       <= pix_vld & pix_last;
                    if (img_rd_en) begin
                        if (img_addr == AW'(IMAGE_SIZE - 1)) begin
                            img_rd_en <= 1'b0;
                            img_addr  <= '0;
                        end else begin
                            img_addr <= img_addr + 1'b1;
                        end
                    end
                    // Leave only after the last pixel has been presented.
                    if (x_last) begin
                        state <= S_SLIDE;
                    end
                end

                S_SLIDE: begin
                    if (win_ready) begin
                        ws_slide <= 1'b1;
                        to_cnt   <= TW'(TIMEOUT - 1);
                        state    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (ws_valid) begin
                        win_valid <= 1'b1;
                        win_index <= idx;
                        win_row   <= row;
                        win_col   <= col;
                        // Counters stop on the last window, so they never
                        // roll into the next frame.
                        if (idx == IW'(NUM_WIN - 1)) begin
                            state <= S_FINISH;
                        end else begin
                            state <= S_SLIDE;
                            idx   <= idx + 1'b1;
                            if (col == CW'(OUT_COLS - 1)) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end else if (to_cnt == '0) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end

                S_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_slide_ctrl.sv
// Testbench for window_slide_ctrl: image buffer and window_slide behavioural
// models, scoreboards for pixel stream and window tags, one task per scenario.

module tb_window_slide_ctrl;

    localparam int ROWS = 10;
    localparam int COLS = 20;
    localparam int K    = 3;
    localparam int TO   = 64;
    localparam int SZ   = ROWS * COLS;
    localparam int AW   = $clog2(SZ);
    // stride 1 instance
    localparam int OR1  = (ROWS - K) / 1 + 1;
    localparam int OC1  = (COLS - K) / 1 + 1;
    localparam int NW1  = OR1 * OC1;
    localparam int IW1  = $clog2(NW1);
    localparam int RW1  = $clog2(OR1);
    localparam int CW1  = $clog2(OC1);
    // stride 2 instance
    localparam int OR2  = (ROWS - K) / 2 + 1;
    localparam int OC2  = (COLS - K) / 2 + 1;
    localparam int NW2  = OR2 * OC2;
    localparam int IW2  = $clog2(NW2);
    localparam int RW2  = $clog2(OR2);
    localparam int CW2  = $clog2(OC2);
    localparam int STALL = 10;
    localparam int BUDGET = 3000;

    typedef struct { int cyc; logic val; logic first; } pix_t;
    typedef struct { int idx; int row; int col; } tag_t;

    logic clk, rst;

    logic           start, busy, done, error, img_rd_en, img_rd_data;
    logic [AW-1:0]  img_addr;
    logic           ws_new_image, ws_x_in, ws_slide, ws_valid, win_ready, win_valid;
    logic [IW1-1:0] win_index;
    logic [RW1-1:0] win_row;
    logic [CW1-1:0] win_col;

    logic           start_b, busy_b, done_b, error_b, img_rd_en_b, img_rd_data_b;
    logic [AW-1:0]  img_addr_b;
    logic           ws_new_image_b, ws_x_in_b, ws_slide_b, ws_valid_b, win_ready_b, win_valid_b;
    logic [IW2-1:0] win_index_b;
    logic [RW2-1:0] win_row_b;
    logic [CW2-1:0] win_col_b;

    window_slide_ctrl #(.IMAGE_ROW_LEN(ROWS), .IMAGE_COL_LEN(COLS), .KERNEL_SIZE(K),
                        .STRIDE(1), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .img_rd_en(img_rd_en), .img_addr(img_addr), .img_rd_data(img_rd_data),
        .ws_new_image(ws_new_image), .ws_x_in(ws_x_in), .ws_slide(ws_slide),
        .ws_valid(ws_valid), .win_ready(win_ready), .win_valid(win_valid),
        .win_index(win_index), .win_row(win_row), .win_col(win_col)
    );

    window_slide_ctrl #(.IMAGE_ROW_LEN(ROWS), .IMAGE_COL_LEN(COLS), .KERNEL_SIZE(K),
                        .STRIDE(2), .TIMEOUT(TO)) u_dut_s2 (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .error(error_b),
        .img_rd_en(img_rd_en_b), .img_addr(img_addr_b), .img_rd_data(img_rd_data_b),
        .ws_new_image(ws_new_image_b), .ws_x_in(ws_x_in_b), .ws_slide(ws_slide_b),
        .ws_valid(ws_valid_b), .win_ready(win_ready_b), .win_valid(win_valid_b),
        .win_index(win_index_b), .win_row(win_row_b), .win_col(win_col_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   nvec, nerr, cyc;
    pix_t pq[$];
    tag_t eq[$];
    tag_t eqb[$];
    logic rd_pend;
    bit   err_prev, ign_finish;
    int   exp_addr, rd_cnt, xbad, nibad, ni_cnt, ni_cyc;
    int   slide_cnt, dly, resp_idx, drop_idx, watch_idx, watch_cyc, first_slide_cyc;
    int   stall_win, stall_left, rel_cyc, stall_slides, dbl_slides, ign_win;
    int   win_cnt, last_win_cyc, last_idx, last_row, last_col;
    int   done_cnt, done_cyc, err_cyc;
    int   dly_b, slide_b_cnt, resp_b, win_b_cnt, last_b_cyc, lb_idx, lb_row, lb_col;
    int   done_b_cnt, done_b_cyc;

    function automatic logic pix_of(int a);
        return ((a / COLS) % 2) == 0;
    endfunction

    task automatic clear_stats();
        exp_addr = 0; rd_cnt = 0; pq.delete(); eq.delete(); eqb.delete();
        xbad = 0; nibad = 0; ni_cnt = 0; ni_cyc = -1;
        slide_cnt = 0; dly = 0; resp_idx = 0; watch_cyc = -1; first_slide_cyc = -1;
        stall_left = 0; rel_cyc = -1; stall_slides = 0; dbl_slides = 0;
        win_cnt = 0; last_win_cyc = -1; last_idx = -1; last_row = -1; last_col = -1;
        done_cnt = 0; done_cyc = -1; err_cyc = -1;
        dly_b = 0; slide_b_cnt = 0; resp_b = 0; win_b_cnt = 0; last_b_cyc = -1;
        lb_idx = -1; lb_row = -1; lb_col = -1; done_b_cnt = 0; done_b_cyc = -1;
    endtask

    // One clock cycle: drive inputs at the falling edge, run models and scoreboards.
    task automatic tick();
        bit   rdy_prev;
        pix_t p;
        tag_t t;
        @(negedge clk);
        cyc++;
        start      = 1'b0;
        start_b    = 1'b0;
        ws_valid   = 1'b0;
        ws_valid_b = 1'b0;
        rdy_prev   = win_ready;

        img_rd_data = rd_pend;
        rd_pend     = 1'b0;
        if (img_rd_en === 1'b1) begin
            nvec++;
            if (img_addr !== AW'(exp_addr)) begin
                nerr++;
                $display("FAIL img_addr: got %0d want %0d", img_addr, exp_addr);
            end
            rd_pend = pix_of(int'(img_addr));
            p.cyc = cyc + 2; p.val = pix_of(exp_addr); p.first = (exp_addr == 0);
            pq.push_back(p);
            exp_addr++;
            rd_cnt++;
        end
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
            p = pq.pop_front();
            nvec++;
            if ({ws_x_in, ws_new_image} !== {p.val, p.first}) begin
                nerr++;
                $display("FAIL pixel: x_in/new_image got %b%b want %b%b", ws_x_in, ws_new_image, p.val, p.first);
            end
        end else begin
            if (ws_x_in !== 1'b0) xbad++;
            if (ws_new_image !== 1'b0) nibad++;
        end
        if (ws_new_image === 1'b1) begin ni_cnt++; ni_cyc = cyc; end

        if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                ws_valid = 1'b1;
                t.idx = resp_idx; t.row = resp_idx / OC1; t.col = resp_idx % OC1;
                eq.push_back(t);
            end
        end
        if (ws_slide === 1'b1) begin
            if (!rdy_prev) stall_slides++;
            if (dly > 0) dbl_slides++;
            if (first_slide_cyc < 0) first_slide_cyc = cyc;
            if (slide_cnt == watch_idx) watch_cyc = cyc;
            if (slide_cnt != drop_idx) begin dly = 2; resp_idx = slide_cnt; end
            slide_cnt++;
        end

        if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) begin win_ready = 1'b1; rel_cyc = cyc; end
        end

        if (win_valid === 1'b1) begin
            win_cnt++; last_win_cyc = cyc;
            last_idx = int'(win_index); last_row = int'(win_row); last_col = int'(win_col);
            nvec++;
            if (eq.size() == 0) begin
                nerr++;
                $display("FAIL win_tag: unexpected window idx %0d, none outstanding", win_index);
            end else begin
                t = eq.pop_front();
                if ({win_index, win_row, win_col} !== {IW1'(t.idx), RW1'(t.row), CW1'(t.col)}) begin
                    nerr++;
                    $display("FAIL win_tag: got %0d/%0d/%0d want %0d/%0d/%0d", win_index, win_row, win_col, t.idx, t.row, t.col);
                end
            end
            if (stall_win >= 0 && int'(win_index) == stall_win) begin
                win_ready = 1'b0; stall_left = STALL;
            end
            if (ign_win >= 0 && int'(win_index) == ign_win) begin
                start = 1'b1; ws_valid = 1'b1;
            end
            if (ign_finish && int'(win_index) == NW1 - 1) start = 1'b1;
        end
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (error === 1'b1 && !err_prev) err_cyc = cyc;
        err_prev = (error === 1'b1);

        // stride-2 instance: window_slide model and tag scoreboard only
        if (dly_b > 0) begin
            dly_b--;
            if (dly_b == 0) begin
                ws_valid_b = 1'b1;
                t.idx = resp_b; t.row = resp_b / OC2; t.col = resp_b % OC2;
                eqb.push_back(t);
            end
        end
        if (ws_slide_b === 1'b1) begin dly_b = 2; resp_b = slide_b_cnt; slide_b_cnt++; end
        if (win_valid_b === 1'b1) begin
            win_b_cnt++; last_b_cyc = cyc;
            lb_idx = int'(win_index_b); lb_row = int'(win_row_b); lb_col = int'(win_col_b);
            nvec++;
            if (eqb.size() == 0) begin
                nerr++;
                $display("FAIL s2_tag: unexpected window idx %0d", win_index_b);
            end else begin
                t = eqb.pop_front();
                if ({win_index_b, win_row_b, win_col_b} !== {IW2'(t.idx), RW2'(t.row), CW2'(t.col)}) begin
                    nerr++;
                    $display("FAIL s2_tag: got %0d/%0d/%0d want %0d/%0d/%0d", win_index_b, win_row_b, win_col_b, t.idx, t.row, t.col);
                end
            end
        end
        if (done_b === 1'b1) begin done_b_cnt++; done_b_cyc = cyc; end
    endtask

    task automatic run_frame(output int c0);
        int n;
        clear_stats();
        start = 1'b1;
        c0 = cyc;
        n = 0;
        while (done_cnt == 0 && err_cyc < 0 && n < BUDGET) begin
            tick();
            n++;
        end
        nvec++;
        if (done_cnt == 0 && err_cyc < 0) begin
            nerr++;
            $display("FAIL frame_end: no done or error after %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        nvec++;
        if ({busy, done, error, img_rd_en, img_addr, ws_new_image, ws_x_in, ws_slide,
             win_valid, win_index, win_row, win_col} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: busy=%b done=%b error=%b rd_en=%b addr=%0d", busy, done, error, img_rd_en, img_addr);
        end
        nvec++;
        if ({busy_b, done_b, error_b, img_rd_en_b, ws_slide_b, win_valid_b} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs_s2: busy=%b rd_en=%b", busy_b, img_rd_en_b);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic check_full_frame(input string name);
        nvec++;
        if (rd_cnt != SZ) begin nerr++; $display("FAIL %s reads: got %0d want %0d", name, rd_cnt, SZ); end
        nvec++;
        if (win_cnt != NW1) begin nerr++; $display("FAIL %s windows: got %0d want %0d", name, win_cnt, NW1); end
        nvec++;
        if (last_idx != NW1 - 1 || last_row != OR1 - 1 || last_col != OC1 - 1) begin
            nerr++;
            $display("FAIL %s last_tag: got %0d/%0d/%0d want %0d/%0d/%0d", name, last_idx, last_row, last_col, NW1 - 1, OR1 - 1, OC1 - 1);
        end
        nvec++;
        if (done_cnt != 1 || done_cyc != last_win_cyc + 1) begin
            nerr++;
            $display("FAIL %s done: count %0d at %0d want 1 at %0d", name, done_cnt, done_cyc, last_win_cyc + 1);
        end
        nvec++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL %s end_flags: error=%b busy=%b want 0 0", name, error, busy);
        end
        nvec++;
        if (dbl_slides != 0) begin nerr++; $display("FAIL %s outstanding: %0d slides while busy want 0", name, dbl_slides); end
    endtask

    task automatic test_normal();
        int c0;
        run_frame(c0);
        check_full_frame("normal");
        nvec++;
        if (ni_cnt != 1 || ni_cyc != c0 + 3) begin
            nerr++;
            $display("FAIL new_image: count %0d at %0d want 1 at %0d", ni_cnt, ni_cyc, c0 + 3);
        end
        nvec++;
        if (xbad != 0 || nibad != 0) begin
            nerr++;
            $display("FAIL stray_pixel: x_in %0d new_image %0d want 0 0", xbad, nibad);
        end
        nvec++;
        if (first_slide_cyc != c0 + SZ + 4) begin
            nerr++;
            $display("FAIL first_slide: got %0d want %0d", first_slide_cyc, c0 + SZ + 4);
        end
        tick();
        nvec++;
        if (done !== 1'b0) begin nerr++; $display("FAIL done_width: done=%b one cycle later want 0", done); end
    endtask

    task automatic test_backpressure();
        int c0;
        stall_win = 5;
        watch_idx = 6;
        run_frame(c0);
        stall_win = -1;
        watch_idx = -1;
        check_full_frame("backpressure");
        nvec++;
        if (stall_slides != 0) begin nerr++; $display("FAIL stall_slide: %0d slides while not ready want 0", stall_slides); end
        nvec++;
        if (rel_cyc < 0 || watch_cyc != rel_cyc + 1) begin
            nerr++;
            $display("FAIL release: window 6 slide at %0d want %0d", watch_cyc, rel_cyc + 1);
        end
    endtask

    task automatic test_timeout();
        int c0;
        drop_idx  = 20;
        watch_idx = 20;
        run_frame(c0);
        drop_idx  = -1;
        watch_idx = -1;
        nvec++;
        if (watch_cyc < 0 || err_cyc != watch_cyc + TO) begin
            nerr++;
            $display("FAIL timeout_time: error at %0d want %0d", err_cyc, watch_cyc + TO);
        end
        nvec++;
        if (busy !== 1'b0 || error !== 1'b1) begin
            nerr++;
            $display("FAIL timeout_flags: busy=%b error=%b want 0 1", busy, error);
        end
        nvec++;
        if (win_cnt != 20) begin nerr++; $display("FAIL timeout_windows: got %0d want 20", win_cnt); end
        repeat (5) tick();
        nvec++;
        if (done_cnt != 0 || error !== 1'b1) begin
            nerr++;
            $display("FAIL timeout_done: done count %0d error=%b want 0 1", done_cnt, error);
        end
        run_frame(c0);
        check_full_frame("after_timeout");
    endtask

    task automatic test_rst_mid_load();
        int c0, n;
        clear_stats();
        start = 1'b1;
        n = 0;
        tick();
        while (!(img_rd_en === 1'b1 && img_addr == AW'(100)) && n < 300) begin
            tick();
            n++;
        end
        nvec++;
        if (n >= 300) begin nerr++; $display("FAIL rst_reach: address 100 not seen"); end
        rst = 1'b1;
        pq.delete();
        tick();
        nvec++;
        if ({busy, done, error, img_rd_en, img_addr, ws_new_image, ws_x_in, ws_slide,
             win_valid, win_index, win_row, win_col} !== '0) begin
            nerr++;
            $display("FAIL rst_mid_load: busy=%b rd_en=%b addr=%0d x_in=%b", busy, img_rd_en, img_addr, ws_x_in);
        end
        rst = 1'b0;
        repeat (3) tick();
        nvec++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL rst_abort: done count %0d busy=%b want 0 0", done_cnt, busy);
        end
        run_frame(c0);
        check_full_frame("after_rst");
        nvec++;
        if (ni_cnt != 1 || ni_cyc != c0 + 3) begin
            nerr++;
            $display("FAIL rst_new_image: count %0d at %0d want 1 at %0d", ni_cnt, ni_cyc, c0 + 3);
        end
    endtask

    task automatic test_ignored_start();
        int c0;
        ign_win    = 10;
        ign_finish = 1'b1;
        run_frame(c0);
        ign_win    = -1;
        ign_finish = 1'b0;
        repeat (4) tick();
        check_full_frame("ignored_start");
    endtask

    task automatic test_stride2();
        int n;
        clear_stats();
        start_b = 1'b1;
        n = 0;
        while (done_b_cnt == 0 && n < BUDGET) begin
            tick();
            n++;
        end
        nvec++;
        if (win_b_cnt != NW2) begin nerr++; $display("FAIL s2_windows: got %0d want %0d", win_b_cnt, NW2); end
        nvec++;
        if (lb_idx != NW2 - 1 || lb_row != OR2 - 1 || lb_col != OC2 - 1) begin
            nerr++;
            $display("FAIL s2_last_tag: got %0d/%0d/%0d want %0d/%0d/%0d", lb_idx, lb_row, lb_col, NW2 - 1, OR2 - 1, OC2 - 1);
        end
        nvec++;
        if (done_b_cnt != 1 || done_b_cyc != last_b_cyc + 1 || error_b !== 1'b0) begin
            nerr++;
            $display("FAIL s2_done: count %0d at %0d error=%b want 1 at %0d error 0", done_b_cnt, done_b_cyc, error_b, last_b_cyc + 1);
        end
    endtask

    initial begin
        nvec = 0; nerr = 0; cyc = 0;
        rst = 1'b1; start = 1'b0; win_ready = 1'b1; ws_valid = 1'b0; img_rd_data = 1'b0;
        start_b = 1'b0; win_ready_b = 1'b1; ws_valid_b = 1'b0; img_rd_data_b = 1'b0;
        rd_pend = 1'b0; err_prev = 1'b0; ign_finish = 1'b0;
        stall_win = -1; drop_idx = -1; watch_idx = -1; ign_win = -1;
        clear_stats();

        test_reset();
        test_normal();
        test_backpressure();
        test_timeout();
        test_rst_mid_load();
        test_ignored_start();
        test_stride2();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
